// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning driver for the 4x4 PmodKYPD keypad.
// Drives one column low at a time and samples the synchronized rows at the end
// of each column period. It reduces every full scan frame to NONE, KEY(code) or
// MULTI, and debounces that frame result across consecutive frames. Accepted
// presses update DispVal and a four-digit history, and pulse key_valid.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic        clock,
    input  logic        reset,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [3:0]  DispVal,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);
    // Candidate / frame result encoding: {is_key, code}; all zeros means NONE.
    localparam logic [4:0]    RES_NONE  = 5'd0;

    typedef enum logic {
        ST_IDLE,
        ST_PRESSED
    } state_t;

    // Map (column index, low row bit) to the hex legend printed on the key.
    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] b);
        logic [3:0] code;
        case ({c, b})
            4'b00_11: code = 4'h1;
            4'b00_10: code = 4'h4;
            4'b00_01: code = 4'h7;
            4'b00_00: code = 4'h0;
            4'b01_11: code = 4'h2;
            4'b01_10: code = 4'h5;
            4'b01_01: code = 4'h8;
            4'b01_00: code = 4'hF;
            4'b10_11: code = 4'h3;
            4'b10_10: code = 4'h6;
            4'b10_01: code = 4'h9;
            4'b10_00: code = 4'hE;
            4'b11_11: code = 4'hA;
            4'b11_10: code = 4'hB;
            4'b11_01: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]    row_s1_q, row_s2_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    acc_lows_q, acc_lows_d;   // lows seen so far this frame, saturating at 2
    logic [3:0]    acc_code_q, acc_code_d;
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    disp_q, disp_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [15:0]   digits_q, digits_d;

    logic          col_end, frame_end;
    logic [2:0]    low_cnt;
    logic [1:0]    low_idx;
    logic [2:0]    lows_sum;
    logic [1:0]    merged_lows;
    logic [3:0]    merged_code;
    logic          res_multi;
    logic [4:0]    res;

    // Column drive: exactly one active-low column, c0 = 0111 ... c3 = 1110.
    always_comb begin
        col = ~(4'b1000 >> col_idx_q);
    end

    // Per-column row decode merged with what the rest of the frame has seen.
    always_comb begin
        low_cnt = 3'd0;
        low_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row_s2_q[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_idx = 2'(i);
            end
        end
        col_end     = (tick_q == TICK_LAST);
        frame_end   = col_end && (col_idx_q == 2'd3);
        lows_sum    = {1'b0, acc_lows_q} + low_cnt;
        merged_lows = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
        merged_code = (low_cnt == 3'd1) ? key_code(col_idx_q, low_idx) : acc_code_q;
        res_multi   = (merged_lows == 2'd2);
        res         = (merged_lows == 2'd1) ? {1'b1, merged_code} : RES_NONE;
    end

    // Scan timing, frame accumulation and candidate/count debounce update.
    always_comb begin
        tick_d     = col_end ? '0 : tick_q + 1'b1;
        col_idx_d  = col_idx_q;
        acc_lows_d = acc_lows_q;
        acc_code_d = acc_code_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        if (col_end) begin
            col_idx_d = col_idx_q + 2'd1;
            if (frame_end) begin
                acc_lows_d = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_lows_d = merged_lows;
                acc_code_d = merged_code;
            end
        end
        if (frame_end) begin
            if (res_multi) begin
                cand_d = RES_NONE;
                cnt_d  = '0;
            end else if (res == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cand_d = res;
                cnt_d  = CW'(1);
            end
        end
    end

    // Debounce FSM next state and registered key outputs.
    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        digits_d    = digits_q;
        if (frame_end && !res_multi && (cnt_d == CNT_MAX)) begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_d[4]) begin
                        state_d     = ST_PRESSED;
                        disp_d      = cand_d[3:0];
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        digits_d    = {digits_q[11:0], cand_d[3:0]};
                    end
                end
                ST_PRESSED: begin
                    // A different stable key is ignored until a stable release.
                    if (!cand_d[4]) begin
                        state_d    = ST_IDLE;
                        key_held_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset; rows pass a 2-FF synchronizer.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            col_idx_q   <= 2'd0;
            tick_q      <= '0;
            acc_lows_q  <= 2'd0;
            acc_code_q  <= 4'd0;
            cand_q      <= RES_NONE;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            disp_q      <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            col_idx_q   <= col_idx_d;
            tick_q      <= tick_d;
            acc_lows_q  <= acc_lows_d;
            acc_code_q  <= acc_code_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            disp_q      <= disp_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    assign DispVal   = disp_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_TICKS=4 and
// DEBOUNCE_SCANS=3 (16-cycle frames). A behavioural keypad pulls a row low
// whenever a pressed key's column is driven. All key changes happen on the
// first cycle of a frame, so each frame sees one consistent key pattern.
module tb_keypad_scanner;

    localparam int FRAME = 16;

    logic        clock;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  DispVal;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits;

    logic [15:0] pressed;     // one bit per hex key code
    int          cyc;
    int          pulse_cnt;
    int          last_pulse_cyc;
    int          errors;
    int          checks;
    int          t0;
    int          exp_pulses;
    logic [3:0]  exp_col [4];
    logic [3:0]  seq_keys [4];

    keypad_scanner #(
        .SCAN_TICKS     (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .DispVal   (DispVal),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digits    (digits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical position of each key: column index (0..3) and row bit (3=top).
    function automatic int key_col(input int k);
        case (k)
            1, 4, 7, 0:        return 0;
            2, 5, 8, 15:       return 1;
            3, 6, 9, 14:       return 2;
            default:           return 3;
        endcase
    endfunction

    function automatic int key_row(input int k);
        case (k)
            1, 2, 3, 10:       return 3;
            4, 5, 6, 11:       return 2;
            7, 8, 9, 12:       return 1;
            default:           return 0;
        endcase
    endfunction

    // Keypad model: a pressed key shorts its row to its column when driven low.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && (col[3 - key_col(k)] == 1'b0)) begin
                row[key_row(k)] = 1'b0;
            end
        end
    end

    // Cycle counter restarting at reset, and key_valid pulse monitor.
    always @(posedge clock) begin
        if (reset) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
        end
        if (key_valid) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clock);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        pulse_cnt      = 0;
        last_pulse_cyc = -1;
        exp_pulses     = 0;
        pressed        = 16'h0000;
        reset          = 1'b1;
        exp_col[0] = 4'b0111; exp_col[1] = 4'b1011;
        exp_col[2] = 4'b1101; exp_col[3] = 4'b1110;
        seq_keys[0] = 4'h1; seq_keys[1] = 4'h2;
        seq_keys[2] = 4'h3; seq_keys[3] = 4'hA;

        // Reset state, then release reset in cycle 0.
        step(3);
        check("rst_col", 16'(col), 16'h0007);
        check("rst_dispval", 16'(DispVal), 16'h0);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_key_held", 16'(key_held), 16'h0);
        check("rst_digits", digits, 16'h0000);
        reset = 1'b0;

        // Idle: column walk for two frames, then no activity for >200 cycles.
        for (int k = 0; k < 2 * FRAME; k++) begin
            check($sformatf("col_seq_c%0d", k), 16'(col), 16'(exp_col[(k / 4) % 4]));
            step(1);
        end
        frames(11);
        check("idle_pulses", 16'(pulse_cnt), 16'(exp_pulses));
        check("idle_dispval", 16'(DispVal), 16'h0);
        check("idle_digits", digits, 16'h0000);
        check("idle_key_held", 16'(key_held), 16'h0);

        // Key 5 held 10 frames: pulse one cycle after the 3rd frame ends.
        t0 = cyc;
        pressed[5] = 1'b1;
        frames(2);
        check("k5_no_early_pulse", 16'(key_valid), 16'h0);
        frames(1);
        check("k5_pulse", 16'(key_valid), 16'h1);
        check("k5_dispval", 16'(DispVal), 16'h5);
        check("k5_digits", digits, 16'h0005);
        check("k5_held", 16'(key_held), 16'h1);
        step(1);
        check("k5_pulse_one_cycle", 16'(key_valid), 16'h0);
        step(FRAME - 1);
        frames(6);
        exp_pulses = exp_pulses + 1;
        check("k5_pulse_count", 16'(pulse_cnt), 16'(exp_pulses));
        check("k5_pulse_cycle", 16'(last_pulse_cyc), 16'(t0 + 3 * FRAME));
        check("k5_still_held", 16'(key_held), 16'h1);
        pressed[5] = 1'b0;
        frames(2);
        check("k5_held_2_release", 16'(key_held), 16'h1);
        frames(1);
        check("k5_released", 16'(key_held), 16'h0);
        check("k5_dispval_kept", 16'(DispVal), 16'h5);

        // Key 7 bouncing KEY/NONE/KEY, then stable.
        pressed[7] = 1'b1;
        frames(1);
        pressed[7] = 1'b0;
        frames(1);
        pressed[7] = 1'b1;
        frames(2);
        check("k7_no_pulse_2nd", 16'(key_valid), 16'h0);
        frames(1);
        check("k7_pulse", 16'(key_valid), 16'h1);
        check("k7_dispval", 16'(DispVal), 16'h7);
        pressed[7] = 1'b0;
        frames(4);
        exp_pulses = exp_pulses + 1;
        check("k7_pulse_count", 16'(pulse_cnt), 16'(exp_pulses));

        // Sequence 1, 2, 3, A: each pressed 4 frames, released 4 frames.
        for (int i = 0; i < 4; i++) begin
            pressed[seq_keys[i]] = 1'b1;
            frames(4);
            pressed[seq_keys[i]] = 1'b0;
            frames(4);
        end
        exp_pulses = exp_pulses + 4;
        check("seq_pulse_count", 16'(pulse_cnt), 16'(exp_pulses));
        check("seq_digits", digits, 16'h123A);
        check("seq_dispval", 16'(DispVal), 16'hA);
        check("seq_key_held", 16'(key_held), 16'h0);

        // Keys 1 and 2 together (MULTI), then 2 alone.
        pressed[1] = 1'b1;
        pressed[2] = 1'b1;
        frames(6);
        check("multi_pulse_count", 16'(pulse_cnt), 16'(exp_pulses));
        check("multi_dispval", 16'(DispVal), 16'hA);
        check("multi_digits", digits, 16'h123A);
        check("multi_key_held", 16'(key_held), 16'h0);
        pressed[1] = 1'b0;
        frames(3);
        check("k2_pulse", 16'(key_valid), 16'h1);
        check("k2_dispval", 16'(DispVal), 16'h2);
        check("k2_digits", digits, 16'h23A2);
        pressed[2] = 1'b0;
        frames(4);
        exp_pulses = exp_pulses + 1;
        check("k2_pulse_count", 16'(pulse_cnt), 16'(exp_pulses));

        // Key 9 for two frames, then a one-cycle reset mid-frame.
        pressed[9] = 1'b1;
        frames(2);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_col", 16'(col), 16'h0007);
        check("mid_rst_dispval", 16'(DispVal), 16'h0);
        check("mid_rst_key_valid", 16'(key_valid), 16'h0);
        check("mid_rst_key_held", 16'(key_held), 16'h0);
        check("mid_rst_digits", digits, 16'h0000);
        check("mid_rst_no_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        frames(2);
        check("k9_no_early_pulse", 16'(key_valid), 16'h0);
        frames(1);
        check("k9_pulse", 16'(key_valid), 16'h1);
        check("k9_dispval", 16'(DispVal), 16'h9);
        check("k9_digits", digits, 16'h0009);
        step(2);
        exp_pulses = exp_pulses + 1;
        check("final_pulse_count", 16'(pulse_cnt), 16'(exp_pulses));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
